mat3_vec_sequencer: RTL

//  Drives a shared 3-cycle pipelined 3-element dot-product unit to compute a 3x3 matrix * 3-vector.
//  - Presents one matrix row plus the vector per cycle on the dp_x*/dp_y* ports.
//  - Collects the three dp_out results into out_vec.
//  - Sits between the vertex/transform stage (upstream valid/ready) and projection (downstream valid/ready).
//  - Issue side of the dot-product interface; the dot-product unit is instantiated externally.

---
 rtl/mat3_vec_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mat3_vec_sequencer.sv
// Issues a 3x3 matrix * 3-vector product to an external DP_LATENCY-deep dot-product unit, one row per cycle.
// Optional MATVEC_TRANSPOSE_EN adds transpose_in to issue columns instead of rows (M^T * v).
module mat3_vec_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DP_LATENCY = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [9*WIDTH-1:0] mat_in,
  input  logic [3*WIDTH-1:0] vec_in,
`ifdef MATVEC_TRANSPOSE_EN
  input  logic               transpose_in,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*WIDTH-1:0] out_vec,
  output logic [WIDTH-1:0]   dp_x0,
  output logic [WIDTH-1:0]   dp_x1,
  output logic [WIDTH-1:0]   dp_x2,
  output logic [WIDTH-1:0]   dp_y0,
  output logic [WIDTH-1:0]   dp_y1,
  output logic [WIDTH-1:0]   dp_y2,
  input  logic [WIDTH-1:0]   dp_out
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] row;
  } tag_t;

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [9*WIDTH-1:0] mat_q;
  logic [3*WIDTH-1:0] vec_q;
  logic [WIDTH-1:0]   x_q [3];
  logic [WIDTH-1:0]   y_q [3];
  logic [WIDTH-1:0]   x_d [3];
  logic [WIDTH-1:0]   y_d [3];
  logic [WIDTH-1:0]   res_q [3];
  tag_t               itag_q, itag_d;
  tag_t               tpipe_q [DP_LATENCY];
  tag_t               emerging;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q;
  logic               accept, issue_en, use_in, src_trn;
  logic [1:0]         issue_row;
  logic [9*WIDTH-1:0] src_mat;
  logic [3*WIDTH-1:0] src_vec;

  function automatic logic [WIDTH-1:0] elem(input logic [9*WIDTH-1:0] m,
                                            input logic [1:0] r, input logic [1:0] c);
    elem = m[(32'(r) * 3 + 32'(c)) * WIDTH +: WIDTH];
  endfunction

  assign accept   = in_valid && in_ready_q;
  assign emerging = tpipe_q[DP_LATENCY-1];
  // Row 0 is issued on the accept edge straight from the inputs; later rows come from the latched copy.
  assign src_mat  = use_in ? mat_in : mat_q;
  assign src_vec  = use_in ? vec_in : vec_q;

`ifdef MATVEC_TRANSPOSE_EN
  logic trn_q;
  assign src_trn = use_in ? transpose_in : trn_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)                            trn_q <= 1'b0;
    else if (state_q == S_IDLE && accept)  trn_q <= transpose_in;
  end
`else
  assign src_trn = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    issue_en    = 1'b0;
    issue_row   = 2'd0;
    use_in      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_ISSUE;
          cnt_d    = 2'd0;
          issue_en = 1'b1;
          use_in   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (cnt_q == 2'd2) begin
          state_d = S_DRAIN;
        end else begin
          issue_en  = 1'b1;
          issue_row = cnt_q + 2'd1;
          cnt_d     = cnt_q + 2'd1;
        end
      end
      S_DRAIN: begin
        if (emerging.vld && emerging.row == 2'd2) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    x_d = '{default: '0};
    y_d = '{default: '0};
    for (int unsigned c = 0; c < 3; c++) begin
      if (issue_en) begin
        x_d[c] = src_trn ? elem(src_mat, 2'(c), issue_row) : elem(src_mat, issue_row, 2'(c));
        y_d[c] = src_vec[c*WIDTH +: WIDTH];
      end
    end
    itag_d = '{vld: issue_en, row: issue_row};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mat_q       <= '0;
      vec_q       <= '0;
      x_q         <= '{default: '0};
      y_q         <= '{default: '0};
      res_q       <= '{default: '0};
      itag_q      <= '0;
      tpipe_q     <= '{default: '0};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      itag_q      <= itag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == S_IDLE);
      if (state_q == S_IDLE && accept) begin
        mat_q <= mat_in;
        vec_q <= vec_in;
      end
      // The tag travels alongside the operands through the unit, so it marks which row dp_out belongs to.
      tpipe_q[0] <= itag_q;
      for (int unsigned i = 1; i < DP_LATENCY; i++) tpipe_q[i] <= tpipe_q[i-1];
      if (emerging.vld) res_q[emerging.row] <= dp_out;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_vec   = {res_q[2], res_q[1], res_q[0]};
  assign dp_x0     = x_q[0];
  assign dp_x1     = x_q[1];
  assign dp_x2     = x_q[2];
  assign dp_y0     = y_q[0];
  assign dp_y1     = y_q[1];
  assign dp_y2     = y_q[2];

endmodule
